clock_reset_seq: RTL and testbench

//  Sequences the PLL-derived system clock domain after power-up and lock loss. Runs on the free-running
//  10 MHz reference and filters the PLL lock. It releases core and peripheral resets in order and

---
 rtl/clock_reset_seq.sv | 195 +++++++++++++++++++
 tb/tb_clock_reset_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_reset_seq.sv
// clock_reset_seq: power-up / lock-loss reset sequencer for the PLL clock domain.
// Runs on the 10 MHz reference, filters the synchronised PLL lock, releases
// core then peripheral reset, pulses the PLL locked-steady reset on every
// lock loss, counts losses seen in RUN and flags a sticky lock timeout.
// Optional feature macro: CLOCK_SEQ_STDY_CHECK_EN (locked-steady drop in RUN
// is treated as a lock loss).
module clock_reset_seq #(
    parameter int unsigned LOCK_CYCLES    = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_10m,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             pll_locked_stdy,
    input  logic             soft_rst,
    output logic             pll_stdy_rst,
    output logic             rst_core_n,
    output logic             rst_periph_n,
    output logic             ready,
    output logic             lock_timeout,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned FILT_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABLE    = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               lk_meta_q, lk_q;
    logic               stdy_loss;

    logic               rst_core_n_q, rst_periph_n_q, ready_q, pll_stdy_rst_q;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

`ifdef CLOCK_SEQ_STDY_CHECK_EN
    logic stdy_meta_q, stdy_q;

    // Two-flop synchroniser for the PLL locked-steady status
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            stdy_meta_q <= 1'b0;
            stdy_q      <= 1'b0;
        end else begin
            stdy_meta_q <= pll_locked_stdy;
            stdy_q      <= stdy_meta_q;
        end
    end

    // Only RUN cares about the steady flag; LOST re-arms it via pll_stdy_rst
    assign stdy_loss = (state_q == S_RUN) && !stdy_q;
`else
    logic unused_stdy;
    assign unused_stdy = pll_locked_stdy;
    assign stdy_loss   = 1'b0;
`endif

    // Next-state and counter logic; lock loss outranks soft_rst outranks normal flow
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        gap_d     = gap_q;
        to_d      = to_q;
        lost_d    = lost_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        if ((!lk_q && (state_q == S_RELEASE || state_q == S_RUN)) || stdy_loss) begin
            state_d = S_LOST;
            lost_d  = 1'b0;
            if (state_q == S_RUN && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end else if (!lk_q && state_q == S_STABLE) begin
            // Loss while filtering just restarts the wait, no LOST pulse
            state_d = S_WAIT_LOCK;
            filt_d  = '0;
        end else if (soft_rst && state_q != S_LOST) begin
            state_d = S_LOST;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (lk_q) begin
                        state_d = S_STABLE;
                        filt_d  = '0;
                    end else if (to_q != TO_LIMIT) begin
                        to_d = to_q + 1'b1;
                        if (to_d == TO_LIMIT)
                            timeout_d = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (filt_q == FILT_LAST) begin
                        state_d = S_RELEASE;
                        gap_d   = '0;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_q == GAP_LAST)
                        state_d = S_RUN;
                    else
                        gap_d = gap_q + 1'b1;
                end
                S_RUN: ;
                S_LOST: begin
                    // Two cycles in LOST give the two-cycle pll_stdy_rst pulse
                    if (lost_q) begin
                        state_d = S_WAIT_LOCK;
                        to_d    = '0;
                    end else begin
                        lost_d = 1'b1;
                    end
                end
                default: state_d = S_WAIT_LOCK;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_LOCK;
            filt_q    <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            lost_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            lost_q    <= lost_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            rst_core_n_q   <= 1'b0;
            rst_periph_n_q <= 1'b0;
            ready_q        <= 1'b0;
            pll_stdy_rst_q <= 1'b0;
        end else begin
            rst_core_n_q   <= (state_d == S_RELEASE) || (state_d == S_RUN);
            rst_periph_n_q <= (state_d == S_RUN);
            ready_q        <= (state_d == S_RUN);
            pll_stdy_rst_q <= (state_d == S_LOST);
        end
    end

    assign rst_core_n    = rst_core_n_q;
    assign rst_periph_n  = rst_periph_n_q;
    assign ready         = ready_q;
    assign pll_stdy_rst  = pll_stdy_rst_q;
    assign lock_timeout  = timeout_q;
    assign lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// Directed bench for clock_reset_seq: LOCK_CYCLES=8, STAGE_GAP=4,
// TIMEOUT_CYCLES=50, CNT_W=2. cyc numbers the edges after reset release.
module tb_clock_reset_seq;

    logic       clk_10m = 1'b0;
    logic       rst_n, pll_locked, pll_locked_stdy, soft_rst;
    logic       pll_stdy_rst, rst_core_n, rst_periph_n, ready, lock_timeout;
    logic [1:0] lock_loss_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int st, c_at, r_at, d;

    clock_reset_seq #(
        .LOCK_CYCLES(8), .STAGE_GAP(4), .TIMEOUT_CYCLES(50), .CNT_W(2)
    ) dut (
        .clk_10m(clk_10m), .rst_n(rst_n), .pll_locked(pll_locked),
        .pll_locked_stdy(pll_locked_stdy), .soft_rst(soft_rst),
        .pll_stdy_rst(pll_stdy_rst), .rst_core_n(rst_core_n),
        .rst_periph_n(rst_periph_n), .ready(ready),
        .lock_timeout(lock_timeout), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_10m = ~clk_10m;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_10m);
        #1;
        cyc++;
    endtask

    // Step until ready rises (bounded); report the edges where core/ready first went high
    task automatic seq_up(output int core_at, output int rdy_at);
        core_at = -1;
        rdy_at  = -1;
        for (int i = 0; i < 60 && rdy_at < 0; i++) begin
            tick();
            if (rst_core_n && core_at < 0) core_at = cyc;
            if (ready && rdy_at < 0) rdy_at = cyc;
        end
    endtask

    // Lock loss in RUN, relock, and full re-sequence
    task automatic loss_cycle(input string tag, input int exp_cnt);
        int s, c, r;
        pll_locked = 1'b0;
        repeat (3) tick();
        chk({tag, "_ready_low"}, int'(ready), 0);
        repeat (5) tick();
        pll_locked = 1'b1;
        s = cyc + 1;
        seq_up(c, r);
        chk({tag, "_core_rise"}, c, s + 10);
        chk({tag, "_cnt"}, int'(lock_loss_cnt), exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; pll_locked_stdy = 1'b1; soft_rst = 1'b0;
        repeat (3) tick();
        chk("rst_core",   int'(rst_core_n), 0);
        chk("rst_periph", int'(rst_periph_n), 0);
        chk("rst_ready",  int'(ready), 0);
        chk("rst_stdy",   int'(pll_stdy_rst), 0);
        chk("rst_tmo",    int'(lock_timeout), 0);
        chk("rst_cnt",    int'(lock_loss_cnt), 0);
        rst_n = 1'b1;
        cyc = 0;

        // 1: power-up, lock first sampled at edge 5
        repeat (4) tick();
        pll_locked = 1'b1;
        seq_up(c_at, r_at);
        chk("pu_core_rise", c_at, 15);
        chk("pu_ready_rise", r_at, 19);
        chk("pu_periph", int'(rst_periph_n), 1);
        chk("pu_cnt", int'(lock_loss_cnt), 0);
        chk("pu_tmo", int'(lock_timeout), 0);

        // 2: lock dropped for 10 sampled edges while in RUN
        pll_locked = 1'b0;
        d = cyc + 1;
        tick(); chk("ll_core_d0", int'(rst_core_n), 1);
        tick(); chk("ll_core_d1", int'(rst_core_n), 1);
        tick();
        chk("ll_core_d2", int'(rst_core_n), 0);
        chk("ll_periph_d2", int'(rst_periph_n), 0);
        chk("ll_ready_d2", int'(ready), 0);
        chk("ll_stdy_d2", int'(pll_stdy_rst), 1);
        chk("ll_cnt", int'(lock_loss_cnt), 1);
        tick(); chk("ll_stdy_d3", int'(pll_stdy_rst), 1);
        tick(); chk("ll_stdy_d4", int'(pll_stdy_rst), 0);
        while (cyc < d + 9) tick();
        pll_locked = 1'b1;
        st = cyc + 1;
        seq_up(c_at, r_at);
        chk("ll_core_rise", c_at, st + 10);
        chk("ll_ready_rise", r_at, st + 14);
        chk("ll_cnt_after", int'(lock_loss_cnt), 1);

        // 5: soft reset in RUN with lock held high
        soft_rst = 1'b1;
        d = cyc + 1;
        tick();
        soft_rst = 1'b0;
        chk("sr_core", int'(rst_core_n), 0);
        chk("sr_ready", int'(ready), 0);
        chk("sr_stdy0", int'(pll_stdy_rst), 1);
        tick(); chk("sr_stdy1", int'(pll_stdy_rst), 1);
        tick(); chk("sr_stdy2", int'(pll_stdy_rst), 0);
        seq_up(c_at, r_at);
        chk("sr_core_rise", c_at, d + 11);
        chk("sr_ready_rise", r_at, d + 15);
        chk("sr_cnt", int'(lock_loss_cnt), 1);

        // 5b: soft_rst on the same edge the loss is acted upon
        pll_locked = 1'b0;
        tick(); tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("both_ready", int'(ready), 0);
        chk("both_cnt", int'(lock_loss_cnt), 2);
        repeat (5) tick();
        pll_locked = 1'b1;
        seq_up(c_at, r_at);
        chk("both_ready_back", int'(ready), 1);

        // 3: bounce while filtering (5 high, 3 low, then high)
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("bn_cnt_loss", int'(lock_loss_cnt), 3);
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        st = cyc + 1;
        seq_up(c_at, r_at);
        chk("bn_core_rise", c_at, st + 10);
        chk("bn_cnt", int'(lock_loss_cnt), 3);

        // 6: further losses keep the 2-bit counter at all-ones
        loss_cycle("sat4", 3);
        loss_cycle("sat5", 3);

        // 6b: rst_n asserted during RELEASE
        pll_locked = 1'b0;
        repeat (8) tick();
        pll_locked = 1'b1;
        for (int i = 0; i < 40 && !rst_core_n; i++) tick();
        chk("rel_reached", int'(rst_core_n), 1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_core",   int'(rst_core_n), 0);
        chk("mrst_periph", int'(rst_periph_n), 0);
        chk("mrst_ready",  int'(ready), 0);
        chk("mrst_stdy",   int'(pll_stdy_rst), 0);
        chk("mrst_tmo",    int'(lock_timeout), 0);
        chk("mrst_cnt",    int'(lock_loss_cnt), 0);
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc = 0;

        // 4: timeout with lock held low, then late lock
        repeat (49) tick();
        chk("to_49", int'(lock_timeout), 0);
        tick();
        chk("to_50", int'(lock_timeout), 1);
        repeat (10) tick();
        chk("to_sticky", int'(lock_timeout), 1);
        chk("to_not_ready", int'(ready), 0);
        pll_locked = 1'b1;
        st = cyc + 1;
        seq_up(c_at, r_at);
        chk("to_ready_rise", r_at, st + 14);
        chk("to_tmo_kept", int'(lock_timeout), 1);
        chk("to_cnt", int'(lock_loss_cnt), 0);

        // Locked-steady drop in RUN
        pll_locked_stdy = 1'b0;
        repeat (3) tick();
`ifdef CLOCK_SEQ_STDY_CHECK_EN
        chk("stdy_ready", int'(ready), 0);
        chk("stdy_pulse", int'(pll_stdy_rst), 1);
        chk("stdy_cnt", int'(lock_loss_cnt), 1);
`else
        chk("stdy_ignored_ready", int'(ready), 1);
        chk("stdy_ignored_cnt", int'(lock_loss_cnt), 0);
`endif
        pll_locked_stdy = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
